// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// The fetch unit imports the same package so that the base address and depth stay consistent.
// IMEM_LOAD_CHECKSUM_EN is the optional macro. When it is defined, the loader also uses the CHK state.
package imem_pkg;

    localparam int          IMEM_DEPTH  = 1024;
    localparam int          IMEM_ADDR_W = 10;
    localparam logic [31:0] IMEM_BASE   = 32'h0000_3000;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CHK  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } imem_state_e;

    // Joins the three earlier bytes with the current byte into one word.
    // The earliest byte ends up in bits [31:24].
    function automatic logic [31:0] pack_be(input logic [23:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: DEPTH x 32 bits.
// It has one synchronous write port for the loader and one asynchronous read port for fetch.
// The RAM has no reset, so its contents survive a loader reset or restart.
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];

    // Write one word when the loader completes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A read shows the old data until the write edge and the new data after it.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a program image into the instruction RAM from a length-prefixed byte stream.
// It holds the CPU in reset until the image is in place.
// Bytes are packed big-endian into 32-bit words.
// Optional macro IMEM_LOAD_CHECKSUM_EN adds a trailing XOR checksum word that must match.
//
// state | meaning
// ------+--------------------------------------------------------------
// HDR   | collecting the 4-byte word count N
// DATA  | collecting N data words, each written on its 4th byte
// CHK   | collecting the 4-byte checksum (checksum build only)
// DONE  | image loaded, CPU released, waiting for restart
// ERR   | bad header or checksum, CPU held, waiting for restart
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    imem_state_e       state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   words_q, words_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic        accept;
    logic        last_byte;
    logic [31:0] word_in;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic        unused_pc_bits;

    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    assign word_in   = pack_be(shift_q, in_data);

    // Fetch indexes the RAM by word, so the byte-offset and upper PC bits are ignored.
    assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

    // All outputs depend only on the registered state (Moore outputs).
    assign in_ready     = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
    assign cpu_hold     = (state_q != DONE);
    assign load_done    = (state_q == DONE);
    assign load_err     = (state_q == ERR);
    assign words_loaded = words_q;

    // Register the state and the counters; reset aborts any load in progress back to HDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HDR;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            n_q        <= '0;
            waddr_q    <= '0;
            words_q    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            n_q        <= n_d;
            waddr_q    <= waddr_d;
            words_q    <= words_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Byte packing, next-state decisions and the RAM write strobe.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        n_d        = n_q;
        waddr_d    = waddr_q;
        words_d    = words_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        ram_we     = 1'b0;
        ram_wdata  = word_in;

        // Packing runs in every accepting state. The counter wraps to 0 after each word.
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], in_data};
        end

        case (state_q)
            HDR: begin
                if (last_byte) begin
                    if ((word_in == 32'd0) || (word_in > 32'(DEPTH))) begin
                        state_d = ERR;
                    end else begin
                        n_d     = word_in[ADDR_W:0];
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (last_byte) begin
                    ram_we  = 1'b1;
                    waddr_d = waddr_q + ADDR_W'(1);
                    words_d = words_q + (ADDR_W+1)'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
                    csum_d  = csum_q ^ word_in;
                    if (words_d == n_q) begin
                        state_d = CHK;
                    end
`else
                    if (words_d == n_q) begin
                        state_d = DONE;
                    end
`endif
                end
            end

            CHK: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                if (last_byte) begin
                    state_d = (word_in == csum_q) ? DONE : ERR;
                end
`else
                state_d = HDR;
`endif
            end

            DONE, ERR: begin
                if (restart) begin
                    state_d    = HDR;
                    byte_cnt_d = 2'd0;
                    waddr_d    = '0;
                    words_d    = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    csum_d     = 32'd0;
`endif
                end
            end

            default: begin
                state_d = HDR;
            end
        endcase
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr_q),
        .wdata (ram_wdata),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (instr)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a scoreboard.
// Stimulus pushes the expected results into a queue. A separate monitor pops and compares
// when a load ends (rising edge of done or err) or when a sample is requested.
// Define IMEM_LOAD_CHECKSUM_EN to append checksums and run the CHK tests.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int ADDR_W = IMEM_ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              restart;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .restart      (restart),
        .pc           (pc),
        .instr        (instr),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    // kind 0: end-of-load event, 1: status sample, 2: instr sample
    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] img[$];
    logic [7:0]  bq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        req = 1'b0;
    logic        prev_fin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] stat(input bit d, input bit e, input bit h, input bit r, input int w);
        return {17'd0, d, e, h, r, w[ADDR_W:0]};
    endfunction

    task automatic take(input int trig);
        exp_t        e;
        logic [31:0] act;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: trigger %0d at cycle %0d, scoreboard empty", trig, cyc);
            return;
        end
        e = sb.pop_front();
        if ((trig == 0 && e.kind != 0) || (trig == 1 && e.kind == 0)) begin
            errors++;
            $display("FAIL %s: trigger %0d but expected kind %0d at cycle %0d", e.name, trig, e.kind, cyc);
            return;
        end
        act = (e.kind == 2) ? instr
                            : {17'd0, load_done, load_err, cpu_hold, in_ready, words_loaded};
        if (act !== e.exp || (e.exp_cyc >= 0 && cyc != e.exp_cyc)) begin
            errors++;
            $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                     e.name, act, cyc, e.exp, e.exp_cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if ((load_done || load_err) && !prev_fin) take(0);
        prev_fin = load_done || load_err;
        if (req) take(1);
    end

    task automatic expect_evt(input string name, input logic [31:0] s, input int c);
        exp_t e;
        e = '{0, name, s, c};
        sb.push_back(e);
    endtask

    task automatic check_snap(input string name, input logic [31:0] s);
        exp_t e;
        e = '{1, name, s, -1};
        sb.push_back(e);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic check_instr(input string name, input logic [31:0] a, input logic [31:0] v);
        exp_t e;
        pc = a;
        e = '{2, name, v, -1};
        sb.push_back(e);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: in_ready low for %0d cycles, required 1", n);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bit stall);
        for (int i = 0; i < bq.size(); i++) begin
            send_byte(bq[i]);
            if (stall && i != bq.size() - 1) @(negedge clk);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        bq.push_back(w[31:24]);
        bq.push_back(w[23:16]);
        bq.push_back(w[15:8]);
        bq.push_back(w[7:0]);
    endtask

    task automatic send_image(input string name, input bit stall, input logic [31:0] s);
        int          nb;
        logic [31:0] cs;
        bq.delete();
        push_word(32'(img.size()));
        cs = 32'd0;
        foreach (img[i]) begin
            push_word(img[i]);
            cs ^= img[i];
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        push_word(cs);
`endif
        nb = bq.size();
        expect_evt(name, s, stall ? cyc + 2 * nb - 1 : cyc + nb);
        send_stream(stall);
    endtask

    task automatic send_bad_header(input string name, input logic [31:0] n);
        bq.delete();
        push_word(n);
        expect_evt(name, stat(0, 1, 1, 0, 0), cyc + 4);
        send_stream(1'b0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_snap("restart_hdr", stat(0, 0, 1, 1, 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset    = 1'b1;
        restart  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        pc       = IMEM_BASE;
        repeat (3) @(negedge clk);
        check_snap("reset_state", stat(0, 0, 1, 1, 0));
        reset = 1'b0;
        @(negedge clk);
        check_snap("after_reset", stat(0, 0, 1, 1, 0));

        img = '{32'h3408_0005, 32'h0000_000C};
        send_image("load2_done", 1'b0, stat(1, 0, 0, 0, 2));
        check_instr("load2_w0", 32'h0000_3000, 32'h3408_0005);
        check_instr("load2_w1", 32'h0000_3004, 32'h0000_000C);

        do_restart();
        send_bad_header("hdr_zero_err", 32'h0000_0000);
        do_restart();
        send_bad_header("hdr_1025_err", 32'h0000_0401);

        do_restart();
        img = '{32'h3408_0005, 32'h0000_000C};
        send_image("stall_done", 1'b1, stat(1, 0, 0, 0, 2));
        check_instr("stall_w0", 32'h0000_3000, 32'h3408_0005);
        check_instr("stall_w1", 32'h0000_3004, 32'h0000_000C);

        do_restart();
        bq = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_stream(1'b0);
        check_snap("midload_words", stat(0, 0, 1, 1, 1));
        reset = 1'b1;
        check_snap("reset_midload", stat(0, 0, 1, 1, 0));
        reset = 1'b0;
        @(negedge clk);
        check_instr("partial_kept", 32'h0000_3000, 32'hAABB_CCDD);
        img = '{32'hDEAD_BEEF};
        send_image("deadbeef_done", 1'b0, stat(1, 0, 0, 0, 1));
        check_instr("deadbeef_w0", 32'h0000_3000, 32'hDEAD_BEEF);
        check_instr("deadbeef_w1", 32'h0000_3004, 32'h0000_000C);

        do_restart();
        img = '{32'h0000_0001};
        send_image("reload_done", 1'b0, stat(1, 0, 0, 0, 1));
        check_instr("reload_w0", 32'h0000_3000, 32'h0000_0001);
        check_instr("reload_w1_kept", 32'h0000_3004, 32'h0000_000C);

        do_restart();
        img.delete();
        for (int i = 0; i < 1024; i++) img.push_back(32'hC0DE_0000 + 32'(i));
        send_image("full_done", 1'b0, stat(1, 0, 0, 0, 1024));
        check_instr("full_last", 32'h0000_3FFC, 32'hC0DE_03FF);
        check_instr("full_w5", 32'h0000_3014, 32'hC0DE_0005);
        check_instr("full_alias", 32'h0000_4000, 32'hC0DE_0000);

`ifdef IMEM_LOAD_CHECKSUM_EN
        do_restart();
        bq.delete();
        push_word(32'h0000_0002);
        push_word(32'h1234_5678);
        push_word(32'h0F0F_0F0F);
        push_word(32'h1D3B_5977);
        expect_evt("csum_ok", stat(1, 0, 0, 0, 2), cyc + 16);
        send_stream(1'b0);
        do_restart();
        bq.delete();
        push_word(32'h0000_0002);
        push_word(32'h1234_5678);
        push_word(32'h0F0F_0F0F);
        push_word(32'h0000_0000);
        expect_evt("csum_bad", stat(0, 1, 1, 0, 2), cyc + 16);
        send_stream(1'b0);
`endif

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: no output observed, expected %h", e.name, e.exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream writer for the instruction memory that the fetch unit reads. It accepts a length-prefixed program image over a valid/ready byte interface and packs bytes big-endian into 32-bit words. It writes the words into a 1024-word instruction RAM starting at index 0 (PC 0x0000_3000) and holds the CPU in reset until the image is complete. It also owns the asynchronous read port the fetch stage indexes with PC[11:2].

## Interface

- DEPTH, default 1024: instruction words in the RAM.
- ADDR_W, default 10: word-index width, log2(DEPTH).

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- in_data  input  8  program byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- restart  input  1  one-cycle pulse; honoured only in DONE/ERR
- pc  input  32  fetch address; read index = pc[ADDR_W+1:2]
- instr  output  32  combinational read data, RAM[pc[11:2]]
- cpu_hold  output  1  high keeps the CPU in reset
- load_done  output  1  image fully and correctly loaded
- load_err  output  1  bad header or checksum
- words_loaded  output  ADDR_W+1  data words written so far

## Operation

- A transfer occurs on a posedge when in_valid && in_ready. A 2-bit byte counter assembles each word; the first byte received is bits [31:24].
- States:
  - HDR: 4 bytes form word count N.
  - DATA: N words.
  - CHK: only with the checksum macro.
  - DONE.
  - ERR.
- HDR, 4th byte: N==0 or N>DEPTH -> ERR; otherwise latch N and go to DATA.
- DATA, 4th byte of a word: write RAM[waddr] on that same edge, then increment waddr and words_loaded. On the word where words_loaded reaches N, go to DONE (or CHK).
- in_ready = 1 in HDR, DATA and CHK; 0 in DONE and ERR. It is Moore: a function of registered state only.
- cpu_hold = 1 in every state except DONE. load_done = (state==DONE). load_err = (state==ERR).
- restart in DONE or ERR: go to HDR, clear the byte counter, waddr and words_loaded, and raise cpu_hold. RAM contents are kept. restart in other states is ignored.
- Reset mid-load aborts immediately to HDR. The partial RAM contents remain; they are not cleared.
- instr reads RAM regardless of state. Indices never written hold undefined data.
- in_valid toggling mid-word stalls the assembly. No timeout exists.

## Timing

- Reset values: state HDR, in_ready 1, cpu_hold 1, load_done 0, load_err 0, words_loaded 0, byte and address counters 0.
- Write latency: a word is visible on instr the cycle after the edge that accepted its 4th byte.
- DONE/ERR outputs assert the cycle after the final accepted byte. in_ready drops in that same cycle.
- Throughput: one byte per cycle; a full 1024-word image plus 4-byte header takes 4100 cycles.
- instr has zero latency from pc. When the same index is being written on an edge, instr shows old data before the edge and new data after.

## Configuration

- IMEM_LOAD_CHECKSUM_EN defined:
  - A running XOR of all data words is accumulated.
  - After the Nth word the loader enters CHK and takes 4 more bytes, packed big-endian.
  - Match -> DONE; mismatch -> ERR.
  - The accumulator clears on reset and on restart.
- Undefined: no CHK state and no accumulator; the last data word goes directly to DONE.

## Structure

- imem_pkg holds:
  - the state enum (HDR, DATA, CHK, DONE, ERR);
  - IMEM_DEPTH = 1024;
  - IMEM_BASE = 32'h0000_3000;
  - IMEM_ADDR_W = 10.
  The fetch unit shares these constants.
- Sub-module imem_ram: DEPTH x 32, one synchronous write port (we, waddr, wdata) and one asynchronous read port. The loader FSM and the byte packer stay in imem_loader.

## Test plan

- Reset, then stream header 00 00 00 02 and words 34 08 00 05, 00 00 00 0C back-to-back -> words_loaded 2. Then pc=0x3000 gives instr 0x34080005 and pc=0x3004 gives 0x0000000C. load_done=1 and cpu_hold=0 one cycle after the last byte.
- Header 00 00 00 00 -> load_err=1 and in_ready=0. Header 00 00 04 01 (1025) -> same.
- Same 2-word image with in_valid low every other cycle -> identical RAM contents and words_loaded 2; DONE occurs later by the number of stall cycles.
- Assert reset after 5 data bytes -> next cycle state HDR, words_loaded 0, cpu_hold 1. Then a fresh 1-word image 0xDEADBEEF -> RAM[0]=0xDEADBEEF.
- In DONE, pulse restart and load a 1-word image 0x00000001 -> RAM[0] is overwritten and RAM[1] keeps its old value.
- With IMEM_LOAD_CHECKSUM_EN, words 0x12345678 and 0x0F0F0F0F:
  - checksum 0x1D3B5977 -> DONE;
  - checksum 0x00000000 -> ERR.
